pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter NSTAGE, default 5, meaning number of pipeline stages (0=IF … NSTAGE-1=WB), range 3..8.
REQ-002 SHALL provide parameter ID_IDX, default 1, meaning index of the decode stage.
REQ-003 SHALL provide parameter BR_IDX, default 2, meaning index of the stage that resolves branches/jumps.
REQ-004 SHALL provide parameter ADDR_W, default 32, meaning PC width.
REQ-005 SHALL provide parameter REG_AW, default 5, meaning register-address width.
REQ-006 clk  in  1  clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 stallreq_i  in  NSTAGE  per-stage multi-cycle stall request (e.g. memory wait).
REQ-009 ex_load_i  in  1  instruction in stage ID_IDX+1 is a load.
REQ-010 ex_wd_i  in  REG_AW  destination register of that load.
REQ-011 id_re1_i, id_re2_i  in  1 each  decode reads rs1/rs2.
REQ-012 id_raddr1_i, id_raddr2_i  in  REG_AW each  decode source addresses.
REQ-013 flush_req_i  in  1  branch/jump taken in stage BR_IDX.
REQ-014 flush_pc_i  in  ADDR_W  redirect target.
REQ-015 stall_o  out  NSTAGE  bit i holds stage-i input register.
REQ-016 bubble_o  out  NSTAGE  bit i loads a NOP into stage-i input register.
REQ-017 pc_we_o  out  1  one-cycle PC redirect strobe.
REQ-018 pc_o  out  ADDR_W  redirect target, valid when pc_we_o=1.
REQ-019 stall_cnt_o, flush_cnt_o  out  32 each  performance counters.

Function
REQ-020 Load-use hazard SHALL be detected as ex_load_i && ex_wd_i!=0 && ((id_re1_i && id_raddr1_i==ex_wd_i) || (id_re2_i && id_raddr2_i==ex_wd_i)) and SHALL act as a stall request from stage ID_IDX.
REQ-021 Effective stall source k SHALL be the highest index with an active request; stall_o[0..k]=1, bubble_o[k+1]=1 if k+1<NSTAGE, all other bits 0; stall_o/bubble_o are combinational, same cycle.
REQ-022 FSM states SHALL be RUN, PEND, REDIR.
REQ-023 RUN: flush_req_i=1 with no stall source ≥BR_IDX -> latch flush_pc_i into target register, go REDIR; with stall source ≥BR_IDX -> latch target, go PEND.
REQ-024 PEND: remain while any stall source ≥BR_IDX is active; flush_req_i ignored; go REDIR the cycle after the stall clears.
REQ-025 REDIR: lasts exactly one cycle; pc_we_o=1, pc_o=target, bubble_o[1..BR_IDX]=1, stall_o[0..BR_IDX-1] forced 0; return to RUN.
REQ-026 In REDIR a simultaneous stall source <BR_IDX SHALL be overridden by the flush; a stall source ≥BR_IDX SHALL still apply to stages above BR_IDX.
REQ-027 flush_req_i asserted in REDIR SHALL be ignored (wrong-path instruction).
REQ-028 Redirect latency SHALL be 1 cycle from flush_req_i to pc_we_o with no blocking stall.
REQ-029 pc_o SHALL hold its last value outside REDIR.

Reset
REQ-030 rst=0 SHALL immediately force state RUN, target 0, pc_we_o 0, counters 0; stall_o and bubble_o SHALL read 0 while rst=0 regardless of inputs.
REQ-031 Reset in PEND or REDIR SHALL discard the pending redirect.

Configuration
REQ-032 Macro PIPE_CTRL_PERF_EN defined: stall_cnt_o increments each cycle any stall_o bit is 1; flush_cnt_o increments on each REDIR cycle; both saturate at 32'hFFFF_FFFF.
REQ-033 PIPE_CTRL_PERF_EN undefined: counter ports remain and SHALL be constant 0, no counter flops.

Structure
REQ-034 FSM state encoding and default stage indices SHALL live in the shared defs package.
REQ-035 One sub-module, pipe_hazard (combinational load-use comparator), SHALL be instantiated; everything else inline.

Verification
REQ-036 ex_load_i=1, ex_wd_i=5, id_re1_i=1, id_raddr1_i=5 -> stall_o=5'b00011, bubble_o=5'b00100 same cycle.
REQ-037 ex_load_i=1, ex_wd_i=0, id_raddr1_i=0 -> stall_o=0, bubble_o=0.
REQ-038 flush_req_i=1, flush_pc_i=32'h0000_0100 -> next cycle pc_we_o=1, pc_o=32'h100, bubble_o=5'b00110, then pc_we_o=0.
REQ-039 stallreq_i[3]=1 for 3 cycles with flush_req_i=1 in first -> PEND 3 cycles, stall_o=5'b01111, pc_we_o=1 in 4th cycle.
REQ-040 rst driven low mid-PEND -> outputs 0 asynchronously, no redirect after release.
REQ-041 PIPE_CTRL_PERF_EN defined, 4 stall cycles and 2 flushes -> stall_cnt_o=4, flush_cnt_o=2; undefined -> both 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared definitions for the pipeline controller
//
// Holds the redirect FSM state encoding and the default stage geometry
// (stage count, decode index, branch-resolve index) used by pipe_ctrl.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PEND  = 2'd1,
        ST_REDIR = 2'd2
    } pipe_state_e;

    localparam int DEF_NSTAGE = 5;
    localparam int DEF_ID_IDX = 1;
    localparam int DEF_BR_IDX = 2;

endpackage

// File: rtl/pipe_hazard.sv
// rtl/pipe_hazard.sv - load-use hazard comparator
//
// Flags when the decode-stage instruction reads a register that the load
// one stage ahead is about to write. Register 0 never carries a hazard.
//
// Ports:
//   ex_load  : instruction after decode is a load
//   ex_wd    : its destination register
//   re1/re2  : decode reads rs1 / rs2
//   raddr1/2 : decode source register addresses
//   hazard   : load-use hazard present (combinational)
module pipe_hazard
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_wd,
    input  logic              re1,
    input  logic              re2,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic              hazard
);

    always_comb begin
        hazard = ex_load && (ex_wd != '0) &&
                 ((re1 && (raddr1 == ex_wd)) || (re2 && (raddr2 == ex_wd)));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/redirect controller
//
// Merges per-stage stall requests with the decode load-use hazard, derives
// per-stage hold (stall_o) and NOP-insert (bubble_o) controls, and sequences
// branch/jump redirects through a RUN/PEND/REDIR FSM. A redirect that arrives
// while a stage at or beyond the branch stage is stalled waits in PEND.
//
// Optional feature: define PIPE_CTRL_PERF_EN to enable the saturating
// stall/flush performance counters; otherwise both counter ports read 0.
//
// Ports:
//   clk, rst             : clock (rising edge), async active-low reset
//   stallreq_i           : per-stage multi-cycle stall requests
//   ex_load_i, ex_wd_i   : load in stage ID_IDX+1 and its destination
//   id_re*_i, id_raddr*_i: decode source register usage
//   flush_req_i/pc_i     : taken branch/jump in stage BR_IDX and its target
//   stall_o, bubble_o    : per-stage hold / NOP-insert (combinational)
//   pc_we_o, pc_o        : one-cycle PC redirect strobe and target
//   stall_cnt_o, flush_cnt_o : performance counters
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NSTAGE = DEF_NSTAGE,
    parameter int ID_IDX = DEF_ID_IDX,
    parameter int BR_IDX = DEF_BR_IDX,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic              ex_load_i,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic              id_re1_i,
    input  logic              id_re2_i,
    input  logic [REG_AW-1:0] id_raddr1_i,
    input  logic [REG_AW-1:0] id_raddr2_i,
    input  logic              flush_req_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-1:0] bubble_o,
    output logic              pc_we_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    pipe_state_e       state;
    logic [ADDR_W-1:0] target_q;
    logic [ADDR_W-1:0] pc_q;
    logic              pc_we_q;

    logic              hazard;
    logic [NSTAGE-1:0] req;
    logic              any_req;
    int                top;
    logic              hi_stall;
    logic [NSTAGE-1:0] stall_n;
    logic [NSTAGE-1:0] bubble_n;

    pipe_hazard #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .ex_load (ex_load_i),
        .ex_wd   (ex_wd_i),
        .re1     (id_re1_i),
        .re2     (id_re2_i),
        .raddr1  (id_raddr1_i),
        .raddr2  (id_raddr2_i),
        .hazard  (hazard)
    );

    always_comb begin
        req         = stallreq_i;
        req[ID_IDX] = stallreq_i[ID_IDX] | hazard;

        // The furthest stalled stage dictates: everything behind it holds,
        // the stage right after it receives a NOP.
        any_req = 1'b0;
        top     = 0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (req[i]) begin
                any_req = 1'b1;
                top     = i;
            end
        end

        // A stall at or beyond the branch stage freezes the branch itself,
        // so a redirect cannot be issued until it releases.
        hi_stall = 1'b0;
        for (int i = BR_IDX; i < NSTAGE; i++) begin
            hi_stall = hi_stall | req[i];
        end

        stall_n  = '0;
        bubble_n = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (any_req && (i <= top))     stall_n[i]  = 1'b1;
            if (any_req && (i == top + 1)) bubble_n[i] = 1'b1;
        end

        // Redirect squashes the wrong-path instructions up to the branch
        // stage; younger stalls there are meaningless and are dropped.
        if (state == ST_REDIR) begin
            for (int i = 0; i < NSTAGE; i++) begin
                if (i < BR_IDX)                stall_n[i]  = 1'b0;
                if ((i >= 1) && (i <= BR_IDX)) bubble_n[i] = 1'b1;
            end
        end

        if (!rst) begin
            stall_n  = '0;
            bubble_n = '0;
        end
    end

    assign stall_o  = stall_n;
    assign bubble_o = bubble_n;
    assign pc_we_o  = pc_we_q;
    assign pc_o     = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            target_q <= '0;
            pc_q     <= '0;
            pc_we_q  <= 1'b0;
        end else begin
            pc_we_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (flush_req_i) begin
                        target_q <= flush_pc_i;
                        if (hi_stall) begin
                            state <= ST_PEND;
                        end else begin
                            state   <= ST_REDIR;
                            pc_we_q <= 1'b1;
                            pc_q    <= flush_pc_i;
                        end
                    end
                end
                ST_PEND: begin
                    if (!hi_stall) begin
                        state   <= ST_REDIR;
                        pc_we_q <= 1'b1;
                        pc_q    <= target_q;
                    end
                end
                ST_REDIR: begin
                    // Any flush seen here comes from a wrong-path instruction.
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((|stall_n) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if ((state == ST_REDIR) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard testbench for pipe_ctrl
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  stallreq_i;
    logic        ex_load_i;
    logic [4:0]  ex_wd_i;
    logic        id_re1_i;
    logic        id_re2_i;
    logic [4:0]  id_raddr1_i;
    logic [4:0]  id_raddr2_i;
    logic        flush_req_i;
    logic [31:0] flush_pc_i;
    logic [4:0]  stall_o;
    logic [4:0]  bubble_o;
    logic        pc_we_o;
    logic [31:0] pc_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    pipe_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .stallreq_i  (stallreq_i),
        .ex_load_i   (ex_load_i),
        .ex_wd_i     (ex_wd_i),
        .id_re1_i    (id_re1_i),
        .id_re2_i    (id_re2_i),
        .id_raddr1_i (id_raddr1_i),
        .id_raddr2_i (id_raddr2_i),
        .flush_req_i (flush_req_i),
        .flush_pc_i  (flush_pc_i),
        .stall_o     (stall_o),
        .bubble_o    (bubble_o),
        .pc_we_o     (pc_we_o),
        .pc_o        (pc_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    typedef struct {
        int          tag;
        logic [4:0]  stall;
        logic [4:0]  bubble;
        logic        pc_we;
        logic [31:0] pc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   tag_n    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            if (stall_o !== mon_e.stall || bubble_o !== mon_e.bubble ||
                pc_we_o !== mon_e.pc_we || pc_o !== mon_e.pc) begin
                failures++;
                $display("FAIL vec%0d stall=%b exp=%b bubble=%b exp=%b pc_we=%b exp=%b pc=%h exp=%h",
                         mon_e.tag, stall_o, mon_e.stall, bubble_o, mon_e.bubble,
                         pc_we_o, mon_e.pc_we, pc_o, mon_e.pc);
            end
        end
    end

    task automatic idle();
        stallreq_i  = '0;
        ex_load_i   = 1'b0;
        ex_wd_i     = '0;
        id_re1_i    = 1'b0;
        id_re2_i    = 1'b0;
        id_raddr1_i = '0;
        id_raddr2_i = '0;
        flush_req_i = 1'b0;
        flush_pc_i  = '0;
    endtask

    task automatic cyc(input logic [4:0] s, input logic [4:0] b,
                       input logic we, input logic [31:0] pc);
        exp_t e;
        e.tag    = tag_n;
        e.stall  = s;
        e.bubble = b;
        e.pc_we  = we;
        e.pc     = pc;
        tag_n++;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_direct(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string name);
        check_direct({name, "_stall"},  {27'd0, stall_o},  32'd0);
        check_direct({name, "_bubble"}, {27'd0, bubble_o}, 32'd0);
        check_direct({name, "_pc_we"},  {31'd0, pc_we_o},  32'd0);
        check_direct({name, "_pc"},     pc_o,              32'd0);
        check_direct({name, "_scnt"},   stall_cnt_o,       32'd0);
        check_direct({name, "_fcnt"},   flush_cnt_o,       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with every request asserted: outputs must stay quiet.
        rst         = 1'b0;
        idle();
        stallreq_i  = 5'b11111;
        flush_req_i = 1'b1;
        flush_pc_i  = 32'hDEAD_BEEF;
        ex_load_i   = 1'b1;
        ex_wd_i     = 5'd5;
        id_re1_i    = 1'b1;
        id_raddr1_i = 5'd5;
        #3;
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();

        // idle
        cyc(5'b00000, 5'b00000, 1'b0, 32'h0);
        // load-use on rs1
        ex_load_i = 1'b1; ex_wd_i = 5'd5; id_re1_i = 1'b1; id_raddr1_i = 5'd5;
        cyc(5'b00011, 5'b00100, 1'b0, 32'h0);
        // load-use on rs2
        id_re1_i = 1'b0; id_raddr1_i = 5'd3; id_re2_i = 1'b1; id_raddr2_i = 5'd5;
        cyc(5'b00011, 5'b00100, 1'b0, 32'h0);
        // destination x0 never hazards
        idle(); ex_load_i = 1'b1; id_re1_i = 1'b1;
        cyc(5'b00000, 5'b00000, 1'b0, 32'h0);
        // address mismatch, matching rs2 not read
        ex_wd_i = 5'd7; id_raddr1_i = 5'd6; id_raddr2_i = 5'd7;
        cyc(5'b00000, 5'b00000, 1'b0, 32'h0);
        // stall from the last stage: no bubble slot
        idle(); stallreq_i = 5'b10000;
        cyc(5'b11111, 5'b00000, 1'b0, 32'h0);
        // highest of several requests wins
        stallreq_i = 5'b00101;
        cyc(5'b00111, 5'b01000, 1'b0, 32'h0);

        // plain redirect
        idle(); flush_req_i = 1'b1; flush_pc_i = 32'h0000_0100;
        cyc(5'b00000, 5'b00000, 1'b0, 32'h0);
        idle();
        cyc(5'b00000, 5'b00110, 1'b1, 32'h100);
        cyc(5'b00000, 5'b00000, 1'b0, 32'h100);

        // flush in REDIR ignored, low stall overridden
        flush_req_i = 1'b1; flush_pc_i = 32'h200;
        cyc(5'b00000, 5'b00000, 1'b0, 32'h100);
        flush_pc_i = 32'h300; stallreq_i = 5'b00010;
        cyc(5'b00000, 5'b00110, 1'b1, 32'h200);
        idle();
        cyc(5'b00000, 5'b00000, 1'b0, 32'h200);
        cyc(5'b00000, 5'b00000, 1'b0, 32'h200);

        // redirect deferred behind a stage-3 stall
        stallreq_i = 5'b01000; flush_req_i = 1'b1; flush_pc_i = 32'h400;
        cyc(5'b01111, 5'b10000, 1'b0, 32'h200);
        flush_pc_i = 32'h999;
        cyc(5'b01111, 5'b10000, 1'b0, 32'h200);
        flush_req_i = 1'b0;
        cyc(5'b01111, 5'b10000, 1'b0, 32'h200);
        idle();
        cyc(5'b00000, 5'b00000, 1'b0, 32'h200);
        cyc(5'b00000, 5'b00110, 1'b1, 32'h400);
        cyc(5'b00000, 5'b00000, 1'b0, 32'h400);

        // high stall arriving during REDIR keeps holding the upper stages
        flush_req_i = 1'b1; flush_pc_i = 32'h500;
        cyc(5'b00000, 5'b00000, 1'b0, 32'h400);
        idle(); stallreq_i = 5'b01000;
        cyc(5'b01100, 5'b10110, 1'b1, 32'h500);
        idle();
        cyc(5'b00000, 5'b00000, 1'b0, 32'h500);

        // reset in the middle of PEND drops the redirect
        stallreq_i = 5'b01000; flush_req_i = 1'b1; flush_pc_i = 32'h600;
        cyc(5'b01111, 5'b10000, 1'b0, 32'h500);
        flush_req_i = 1'b0;
        cyc(5'b01111, 5'b10000, 1'b0, 32'h500);
        #2;
        rst = 1'b0;
        #1;
        check_zero_outputs("midpend_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        cyc(5'b00000, 5'b00000, 1'b0, 32'h0);
        cyc(5'b00000, 5'b00000, 1'b0, 32'h0);
        cyc(5'b00000, 5'b00000, 1'b0, 32'h0);

        // counter workload: 4 stall cycles, 2 redirects
        stallreq_i = 5'b00001;
        for (int i = 0; i < 4; i++) cyc(5'b00001, 5'b00010, 1'b0, 32'h0);
        idle(); flush_req_i = 1'b1; flush_pc_i = 32'h700;
        cyc(5'b00000, 5'b00000, 1'b0, 32'h0);
        idle();
        cyc(5'b00000, 5'b00110, 1'b1, 32'h700);
        flush_req_i = 1'b1; flush_pc_i = 32'h800;
        cyc(5'b00000, 5'b00000, 1'b0, 32'h700);
        idle();
        cyc(5'b00000, 5'b00110, 1'b1, 32'h800);
        cyc(5'b00000, 5'b00000, 1'b0, 32'h800);
`ifdef PIPE_CTRL_PERF_EN
        check_direct("stall_cnt", stall_cnt_o, 32'd4);
        check_direct("flush_cnt", flush_cnt_o, 32'd2);
`else
        check_direct("stall_cnt", stall_cnt_o, 32'd0);
        check_direct("flush_cnt", flush_cnt_o, 32'd0);
`endif

        @(negedge clk);
        #1;
        check_direct("scoreboard_drain", sbq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
